wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Write-side companion to the 32x32 register file: owns the RF write port (regwrite/rd/write_data) and tracks destination registers reserved by long-latency units (multiplier/divider, multi-cycle load).
- Queues their results in a DEPTH-entry FIFO and merges them with single-cycle datapath writes, one RF write per cycle.
- Raises a read-hazard flag when rs1/rs2 names a register whose result is still outstanding.

Parameters:
- DEPTH, 4, result FIFO entries and max outstanding reservations (power of 2, >=2).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  long-latency op wants to reserve issue_rd
- issue_rd  in  5  destination being reserved
- issue_ready  out  1  reservation accepted this cycle when high with issue_valid
- res_valid  in  1  result returned by long-latency unit
- res_rd  in  5  result destination
- res_data  in  XLEN  result value
- res_ready  out  1  FIFO can accept result
- core_wr_valid  in  1  single-cycle datapath writes this cycle
- core_rd  in  5  datapath destination
- core_data  in  XLEN  datapath write data
- rf_regwrite  out  1  to register file regwrite
- rf_rd  out  5  to register file rd
- rf_write_data  out  XLEN  to register file write_data
- rs1  in  5  decode read address 1
- rs2  in  5  decode read address 2
- hazard  out  1  stall decode: rs1 or rs2 pending
- pending  out  32  reservation bitmask, bit0 always 0
- outstanding  out  $clog2(DEPTH+1)  reservations not yet written to RF
- err  out  1  sticky protocol-violation flag
- fwd1_en, fwd2_en  out  1  forward valid (see Optional Feature)
- fwd1_data, fwd2_data  out  XLEN  forward data

Behaviour:
- Reset (async, immediate): FIFO empty, pending=0, outstanding=0, err=0.
  - Outputs during reset: res_ready=1, hazard=0, fwd*=0.
  - rf_* follow the combinational rules below; FIFO is empty, so rf_regwrite = core_wr_valid && core_rd!=0.
- Reset mid-operation drops all queued results and reservations.
- issue_ready = !pending[issue_rd] && outstanding<DEPTH (combinational).
- Issue accept (issue_valid && issue_ready), rd!=0: pending[rd] set at the edge; outstanding +1.
- Issue with rd==0: accepted, no state change.
- Result path:
  - res_ready = !full; no same-cycle enqueue bypass when full.
  - Accept with res_rd!=0 enqueues {rd,data}.
  - res_rd==0: accepted and discarded.
  - res_rd not pending: still enqueued, err set.
- RF write mux (combinational, lands at next edge):
  - core_wr_valid has priority: rf_regwrite = (core_rd!=0), rf_rd=core_rd, rf_write_data=core_data.
  - Else if FIFO non-empty: drive FIFO head with rf_regwrite=1; head pops at the edge.
  - Else rf_regwrite=0, rf_rd=0, rf_write_data=0.
- Drain: on head pop, pending[head.rd] clears and outstanding -1 at the same edge.
  - Simultaneous issue accept and pop: outstanding unchanged; issue_ready uses pre-edge values.
- Minimum latency is 1 cycle: a result accepted at edge N is written to RF at edge N+1 if the core is idle.
- Core write to a pending rd: performed, err set, pending unchanged.
- Pointers wrap modulo DEPTH.
- Full and empty are distinguished by a count, not by pointer equality.
- hazard = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]), subject to the forwarding exclusion below.
- err clears only on reset.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - fwd1_en = 1 when the FIFO head is being written this cycle and head.rd==rs1!=0; fwd1_data = head.data. fwd2 is the same for rs2.
  - hazard excludes a source whose fwd*_en is 1.
- Undefined: fwd*_en=0 and fwd*_data=0 constantly; hazard uses pending only.

Test Plan:
- Issue rd=5, result rd=5 data=0xDEADBEEF, core idle -> pending[5]=1 and hazard=1 for rs1=5; one cycle later rf_regwrite=1, rf_rd=5, data 0xDEADBEEF; then pending[5]=0, outstanding=0.
- Issue rd=3 then issue rd=3 again -> second has issue_ready=0; DEPTH=4 issues to rd 1..4 -> fifth issue refused until a pop.
- Result queued for rd=7 while core_wr_valid=1 (rd=9) for 3 cycles -> rd=9 written each cycle, rd=7 written on the first idle cycle, FIFO order preserved for 4 queued results.
- Result with res_rd=12 never issued -> err=1 sticky; res_rd=0 -> discarded, no RF write; rst pulse mid-drain -> FIFO empty, pending=0 immediately.
- Issue rd=6 on the same cycle as the head pop for rd=2 -> pending[6]=1, pending[2]=0, outstanding unchanged.
- WB_FWD_EN: head rd=8 draining with rs2=8 -> fwd2_en=1, fwd2_data=head data, hazard=0. Same stimulus without the macro -> hazard=1, fwd2_en=0.

Source files
------------

// File: rtl/wb_scoreboard.sv
// Write-back scoreboard: reserves long-latency destinations, queues their results and
// merges them with core writes onto the single RF write port. Optional forwarding: WB_FWD_EN.
module wb_scoreboard #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [4:0]                   issue_rd,
  output logic                         issue_ready,
  input  logic                         res_valid,
  input  logic [4:0]                   res_rd,
  input  logic [XLEN-1:0]              res_data,
  output logic                         res_ready,
  input  logic                         core_wr_valid,
  input  logic [4:0]                   core_rd,
  input  logic [XLEN-1:0]              core_data,
  output logic                         rf_regwrite,
  output logic [4:0]                   rf_rd,
  output logic [XLEN-1:0]              rf_write_data,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  output logic                         hazard,
  output logic [31:0]                  pending,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         err,
  output logic                         fwd1_en,
  output logic                         fwd2_en,
  output logic [XLEN-1:0]              fwd1_data,
  output logic [XLEN-1:0]              fwd2_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            empty;
  logic            issue_set;
  logic            res_acc;
  logic            enq;
  logic            pop;
  logic            dec;
  logic            err_set;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic [31:0]     pending_next;

  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign res_ready = !full;

  assign issue_ready = !pending[issue_rd] && (outstanding < CW'(DEPTH));
  assign issue_set   = issue_valid && issue_ready && (issue_rd != 5'd0);

  assign res_acc = res_valid && res_ready;
  assign enq     = res_acc && (res_rd != 5'd0);
  assign pop     = !core_wr_valid && !empty;

  // A stray (never reserved) result owns no reservation, so it must not decrement.
  assign dec = pop && pending[head_rd];

  assign err_set = (enq && !pending[res_rd]) ||
                   (core_wr_valid && (core_rd != 5'd0) && pending[core_rd]);

  always_comb begin
    rf_regwrite   = 1'b0;
    rf_rd         = 5'd0;
    rf_write_data = '0;
    if (core_wr_valid) begin
      rf_regwrite   = (core_rd != 5'd0);
      rf_rd         = core_rd;
      rf_write_data = core_data;
    end else if (!empty) begin
      rf_regwrite   = 1'b1;
      rf_rd         = head_rd;
      rf_write_data = head_data;
    end
  end

`ifdef WB_FWD_EN
  assign fwd1_en   = pop && (rs1 != 5'd0) && (head_rd == rs1);
  assign fwd2_en   = pop && (rs2 != 5'd0) && (head_rd == rs2);
  assign fwd1_data = fwd1_en ? head_data : '0;
  assign fwd2_data = fwd2_en ? head_data : '0;
`else
  assign fwd1_en   = 1'b0;
  assign fwd2_en   = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

  assign hazard = ((rs1 != 5'd0) && pending[rs1] && !fwd1_en) ||
                  ((rs2 != 5'd0) && pending[rs2] && !fwd2_en);

  // Set after clear so a re-issue of the draining register stays reserved.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head_rd] = 1'b0;
    if (issue_set) pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pending     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd[i]   <= 5'd0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (enq) begin
        fifo_rd[wr_ptr]   <= res_rd;
        fifo_data[wr_ptr] <= res_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case ({issue_set, dec})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      pending <= pending_next;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: table-driven cycles plus a result scoreboard that
// predicts every RF write and forward; hand sequences cover reset and error cases.
module tb_wb_scoreboard;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic            res_valid;
  logic [4:0]      res_rd;
  logic [XLEN-1:0] res_data;
  logic            res_ready;
  logic            core_wr_valid;
  logic [4:0]      core_rd;
  logic [XLEN-1:0] core_data;
  logic            rf_regwrite;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_write_data;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            hazard;
  logic [31:0]     pending;
  logic [2:0]      outstanding;
  logic            err;
  logic            fwd1_en;
  logic            fwd2_en;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;

  wb_scoreboard #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .res_ready(res_ready),
    .core_wr_valid(core_wr_valid), .core_rd(core_rd), .core_data(core_data),
    .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .pending(pending),
    .outstanding(outstanding), .err(err),
    .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        rv;
    logic [4:0]  rrd;
    logic [31:0] rdata;
    logic        cv;
    logic [4:0]  crd;
    logic [31:0] cdata;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_ir;
    logic        e_hz;
    logic [31:0] e_pend;
    int          e_out;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  vec_t tbl[$];
  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic [4:0] ird, logic rv, logic [4:0] rrd,
                              logic [31:0] rdata, logic cv, logic [4:0] crd,
                              logic [31:0] cdata, logic [4:0] s1, logic [4:0] s2,
                              logic e_ir, logic e_hz, logic [31:0] e_pend,
                              int e_out, logic e_err);
    vec_t v;
    v.iv = iv; v.ird = ird; v.rv = rv; v.rrd = rrd; v.rdata = rdata;
    v.cv = cv; v.crd = crd; v.cdata = cdata; v.s1 = s1; v.s2 = s2;
    v.e_ir = e_ir; v.e_hz = e_hz; v.e_pend = e_pend; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    issue_valid = 1'b0; issue_rd = 5'd0;
    res_valid = 1'b0; res_rd = 5'd0; res_data = '0;
    core_wr_valid = 1'b0; core_rd = 5'd0; core_data = '0;
    rs1 = 5'd0; rs2 = 5'd0;
  endtask

  // Pre-edge view: table state fields plus scoreboard predictions for the write port.
  task automatic checkOutput(input vec_t v);
    logic        e_f1;
    logic        e_f2;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    check("issue_ready", 64'(issue_ready), 64'(v.e_ir));
    check("hazard", 64'(hazard), 64'(v.e_hz));
    check("pending", 64'(pending), 64'(v.e_pend));
    check("outstanding", 64'(outstanding), 64'(v.e_out));
    check("err", 64'(err), 64'(v.e_err));
    check("res_ready", 64'(res_ready), 64'(exp_q.size() < DEPTH));
    e_f1 = 1'b0; e_f2 = 1'b0; e_d1 = '0; e_d2 = '0;
    if (v.cv) begin
      check("rf_regwrite_core", 64'(rf_regwrite), 64'(v.crd != 5'd0));
      check("rf_rd_core", 64'(rf_rd), 64'(v.crd));
      check("rf_data_core", 64'(rf_write_data), 64'(v.cdata));
    end else if (exp_q.size() > 0) begin
      check("rf_regwrite_fifo", 64'(rf_regwrite), 64'd1);
      check("rf_rd_fifo", 64'(rf_rd), 64'(exp_q[0].rd));
      check("rf_data_fifo", 64'(rf_write_data), 64'(exp_q[0].data));
      if (FWD && v.s1 != 5'd0 && exp_q[0].rd == v.s1) begin e_f1 = 1'b1; e_d1 = exp_q[0].data; end
      if (FWD && v.s2 != 5'd0 && exp_q[0].rd == v.s2) begin e_f2 = 1'b1; e_d2 = exp_q[0].data; end
    end else begin
      check("rf_regwrite_idle", 64'(rf_regwrite), 64'd0);
      check("rf_rd_idle", 64'(rf_rd), 64'd0);
      check("rf_data_idle", 64'(rf_write_data), 64'd0);
    end
    check("fwd1_en", 64'(fwd1_en), 64'(e_f1));
    check("fwd2_en", 64'(fwd2_en), 64'(e_f2));
    check("fwd1_data", 64'(fwd1_data), 64'(e_d1));
    check("fwd2_data", 64'(fwd2_data), 64'(e_d2));
  endtask

  task automatic applyStimulus(input vec_t v);
    logic acc;
    res_t r;
    issue_valid = v.iv; issue_rd = v.ird;
    res_valid = v.rv; res_rd = v.rrd; res_data = v.rdata;
    core_wr_valid = v.cv; core_rd = v.crd; core_data = v.cdata;
    rs1 = v.s1; rs2 = v.s2;
    #2;
    checkOutput(v);
    acc = v.rv && (exp_q.size() < DEPTH) && (v.rrd != 5'd0);
    if (!v.cv && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) begin
      r.rd = v.rrd; r.data = v.rdata;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    #2;
    check("reset_pending", 64'(pending), 64'd0);
    check("reset_outstanding", 64'(outstanding), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_res_ready", 64'(res_ready), 64'd1);
    check("reset_hazard", 64'(hazard), 64'd0);
    check("reset_regwrite", 64'(rf_regwrite), 64'd0);
    check("reset_fwd", 64'({fwd1_en, fwd2_en}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic reserve / result / drain, latency one cycle.
    tbl.push_back(mk(1, 5,  0, 0, 0,            0, 0, 0,  5, 0,  1, 0,    32'h0,  0, 0));
    tbl.push_back(mk(0, 0,  1, 5, 32'hDEADBEEF, 0, 0, 0,  5, 0,  1, 1,    32'h20, 1, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,  5, 0,  1, !FWD, 32'h20, 1, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,  5, 0,  1, 0,    32'h0,  0, 0));
    // Issue to x0, duplicate issue, fill to DEPTH, refuse, drain with issue-on-pop.
    tbl.push_back(mk(1, 0,  0, 0, 0,            0, 0, 0,  0, 0,  1, 0,    32'h0,  0, 0));
    tbl.push_back(mk(1, 3,  0, 0, 0,            0, 0, 0,  0, 0,  1, 0,    32'h0,  0, 0));
    tbl.push_back(mk(1, 3,  0, 0, 0,            0, 0, 0,  0, 3,  0, 1,    32'h8,  1, 0));
    tbl.push_back(mk(1, 1,  0, 0, 0,            0, 0, 0,  0, 0,  1, 0,    32'h8,  1, 0));
    tbl.push_back(mk(1, 2,  0, 0, 0,            0, 0, 0,  0, 0,  1, 0,    32'hA,  2, 0));
    tbl.push_back(mk(1, 4,  0, 0, 0,            0, 0, 0,  0, 0,  1, 0,    32'hE,  3, 0));
    tbl.push_back(mk(1, 5,  0, 0, 0,            0, 0, 0,  0, 0,  0, 0,    32'h1E, 4, 0));
    tbl.push_back(mk(0, 0,  1, 3, 32'hA3,       0, 0, 0,  0, 0,  0, 0,    32'h1E, 4, 0));
    tbl.push_back(mk(1, 5,  1, 1, 32'hB1,       0, 0, 0,  0, 0,  0, 0,    32'h1E, 4, 0));
    tbl.push_back(mk(0, 0,  1, 2, 32'hC2,       0, 0, 0,  0, 0,  1, 0,    32'h16, 3, 0));
    tbl.push_back(mk(1, 6,  1, 4, 32'hD4,       0, 0, 0,  0, 0,  1, 0,    32'h14, 2, 0));
    tbl.push_back(mk(0, 0,  1, 6, 32'hE6,       0, 0, 0,  6, 0,  1, 1,    32'h50, 2, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,  6, 0,  1, !FWD, 32'h40, 1, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,  0, 0,  1, 0,    32'h0,  0, 0));
    // Core priority over queued result, then FIFO order with full back-pressure.
    tbl.push_back(mk(1, 7,  0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'h0,      0, 0));
    tbl.push_back(mk(0, 0,  1, 7, 32'h77,       1, 9, 32'h900,  0, 0,  1, 0, 32'h80,     1, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            1, 9, 32'h901,  0, 0,  1, 0, 32'h80,     1, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            1, 9, 32'h902,  0, 0,  1, 0, 32'h80,     1, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'h80,     1, 0));
    tbl.push_back(mk(1, 20, 0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'h0,      0, 0));
    tbl.push_back(mk(1, 21, 0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'h100000, 1, 0));
    tbl.push_back(mk(1, 22, 0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'h300000, 2, 0));
    tbl.push_back(mk(1, 23, 0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'h700000, 3, 0));
    tbl.push_back(mk(0, 0,  1, 20, 32'hA0,      1, 9, 32'h910,  0, 0,  0, 0, 32'hF00000, 4, 0));
    tbl.push_back(mk(0, 0,  1, 21, 32'hA1,      1, 9, 32'h911,  0, 0,  0, 0, 32'hF00000, 4, 0));
    tbl.push_back(mk(0, 0,  1, 22, 32'hA2,      1, 9, 32'h912,  0, 0,  0, 0, 32'hF00000, 4, 0));
    tbl.push_back(mk(0, 0,  1, 23, 32'hA3,      1, 9, 32'h913,  0, 0,  0, 0, 32'hF00000, 4, 0));
    tbl.push_back(mk(0, 0,  1, 21, 32'hBAD,     1, 9, 32'h914,  0, 0,  0, 0, 32'hF00000, 4, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'hF00000, 4, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'hE00000, 3, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'hC00000, 2, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'h800000, 1, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,        0, 0,  1, 0, 32'h0,      0, 0));
    // Stray result sets sticky err; result to x0 is dropped.
    tbl.push_back(mk(0, 0,  1, 12, 32'hC,       0, 0, 0,  0, 0,  1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,  0, 0,  1, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0,  1, 0, 32'h55,       0, 0, 0,  0, 0,  1, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0,  0, 0, 0,            0, 0, 0,  0, 0,  1, 0, 32'h0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    // Asynchronous reset in the middle of a pending drain.
    applyStimulus(mk(1, 17, 0, 0, 0,        0, 0, 0,       0, 0,  1, 0, 32'h0,     0, 1));
    applyStimulus(mk(1, 18, 0, 0, 0,        0, 0, 0,       0, 0,  1, 0, 32'h20000, 1, 1));
    applyStimulus(mk(0, 0,  1, 17, 32'h171, 1, 9, 32'h99,  0, 0,  1, 0, 32'h60000, 2, 1));
    applyStimulus(mk(0, 0,  1, 18, 32'h181, 1, 9, 32'h98,  0, 0,  1, 0, 32'h60000, 2, 1));
    set_idle();
    rs1 = 5'd17;
    rst = 1'b1;
    #1;
    check("midrst_pending", 64'(pending), 64'd0);
    check("midrst_outstanding", 64'(outstanding), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_res_ready", 64'(res_ready), 64'd1);
    check("midrst_hazard", 64'(hazard), 64'd0);
    check("midrst_regwrite", 64'(rf_regwrite), 64'd0);
    core_wr_valid = 1'b1; core_rd = 5'd4; core_data = 32'h44;
    #1;
    check("rst_core_regwrite", 64'(rf_regwrite), 64'd1);
    check("rst_core_rd", 64'(rf_rd), 64'd4);
    check("rst_core_data", 64'(rf_write_data), 64'h44);
    exp_q.delete();
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b0;

    // Core write to a reserved register: performed, err set, reservation kept.
    applyStimulus(mk(1, 15, 0, 0, 0,         0, 0, 0,          0, 0,  1, 0, 32'h0,    0, 0));
    applyStimulus(mk(0, 0,  0, 0, 0,         1, 15, 32'hF0F0,  0, 0,  1, 0, 32'h8000, 1, 0));
    applyStimulus(mk(0, 0,  1, 15, 32'h1515, 0, 0, 0,          0, 0,  1, 0, 32'h8000, 1, 1));
    applyStimulus(mk(0, 0,  0, 0, 0,         0, 0, 0,          0, 0,  1, 0, 32'h8000, 1, 1));
    applyStimulus(mk(0, 0,  0, 0, 0,         0, 0, 0,          0, 0,  1, 0, 32'h0,    0, 1));

    // Forwarding window: only while the head for rs2 is actually being written.
    applyStimulus(mk(1, 8,  0, 0, 0,         0, 0, 0,         0, 8,  1, 0,    32'h0,   0, 1));
    applyStimulus(mk(0, 0,  1, 8, 32'h88,    1, 9, 32'h990,   0, 8,  1, 1,    32'h100, 1, 1));
    applyStimulus(mk(0, 0,  0, 0, 0,         1, 9, 32'h991,   0, 8,  1, 1,    32'h100, 1, 1));
    applyStimulus(mk(0, 0,  0, 0, 0,         0, 0, 0,         0, 8,  1, !FWD, 32'h100, 1, 1));
    applyStimulus(mk(0, 0,  0, 0, 0,         0, 0, 0,         0, 8,  1, 0,    32'h0,   0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
